// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit and receive engines: frame length,
// parity sense encodings, the engine state type, and the frame builder used by
// the transmitter.
package uart_pkg;

    localparam int   FRAME_LEN = 11;
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    typedef enum logic {
        IDLE,
        SHIFT
    } tx_state_t;

    // Builds the 11-bit frame, right-aligned so bit 0 (start) leaves the line first.
    // Bit positions not used by data or parity are stop/padding ones.
    function automatic logic [FRAME_LEN-1:0] build_frame(
        input logic [7:0] data,
        input logic       eight,
        input logic       pen,
        input logic       ohel
    );
        logic                 par;
        logic [FRAME_LEN-1:0] frame;
        if (eight) begin
            par   = (ohel == PAR_ODD) ? ~^data : ^data;
            frame = {1'b1, (pen ? par : 1'b1), data, 1'b0};
        end else begin
            par   = (ohel == PAR_ODD) ? ~^data[6:0] : ^data[6:0];
            frame = {2'b11, (pen ? par : 1'b1), data[6:0], 1'b0};
        end
        return frame;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen
// Bit-time counter: counts 0..K-1 and asserts tick while the count is K-1, then
// wraps. K=0 behaves as K=1 (tick every clock).
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   clr   in  restart the bit-time from count 0
//   k     in  clocks per bit-time
//   tick  out high on the last clock of each bit-time
module baud_tick_gen #(
    parameter int BAUD_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic [BAUD_W-1:0] k,
    output logic              tick
);

    logic [BAUD_W-1:0] cnt_q;
    logic [BAUD_W-1:0] cnt_last;

    assign cnt_last = (k == '0) ? '0 : k - BAUD_W'(1);
    assign tick     = (cnt_q == cnt_last);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + BAUD_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine
// UART transmit engine. Accepts a byte with a ready/load handshake and shifts
// an 11-bit-time frame out LSB-first on O_TX, each bit held K clocks.
// Ports:
//   I_CLK     in  system clock
//   I_RESET   in  synchronous active-high reset
//   I_DATA    in  byte to send (bit 7 unused in 7-bit mode)
//   I_LOAD    in  start request, taken only while O_TXRDY=1
//   I_BAUD_K  in  clocks per bit-time (0 acts as 1)
//   I_EIGHT   in  1 = 8 data bits, 0 = 7 data bits
//   I_PEN     in  parity enable
//   I_OHEL    in  parity sense, 1 = odd
//   O_TX      out serial line, idle high (registered)
//   O_TXRDY   out idle / ready for a load (registered)
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int BAUD_W = 20
) (
    input  logic              I_CLK,
    input  logic              I_RESET,
    input  logic [7:0]        I_DATA,
    input  logic              I_LOAD,
    input  logic [BAUD_W-1:0] I_BAUD_K,
    input  logic              I_EIGHT,
    input  logic              I_PEN,
    input  logic              I_OHEL,
    output logic              O_TX,
    output logic              O_TXRDY
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

    tx_state_t            state_q, next_state;
    logic                 load_go;
    logic                 frame_done;
    logic                 tick;
    logic [FRAME_LEN-1:0] shift_q;
    logic [3:0]           bit_cnt_q;
    logic [BAUD_W-1:0]    k_q;
    logic                 txrdy_q;

    baud_tick_gen #(
        .BAUD_W(BAUD_W)
    ) u_baud (
        .clk  (I_CLK),
        .reset(I_RESET),
        .clr  (load_go),
        .k    (k_q),
        .tick (tick)
    );

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state = state_q;
        load_go    = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (I_LOAD) begin
                    load_go    = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (tick && bit_cnt_q == LAST_BIT) begin
                    frame_done = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The shift register holds the fully formatted frame, so data, width and
    // parity settings are captured once at load; only K needs its own shadow.
    // shift_q[0] is the line itself, which keeps O_TX a plain flop output.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            shift_q   <= '1;
            bit_cnt_q <= '0;
            k_q       <= '0;
            txrdy_q   <= 1'b1;
        end else if (load_go) begin
            shift_q   <= build_frame(I_DATA, I_EIGHT, I_PEN, I_OHEL);
            bit_cnt_q <= '0;
            k_q       <= I_BAUD_K;
            txrdy_q   <= 1'b0;
        end else if (state_q == SHIFT && tick) begin
            shift_q <= {1'b1, shift_q[FRAME_LEN-1:1]};
            if (bit_cnt_q != LAST_BIT) begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (frame_done) begin
                txrdy_q <= 1'b1;
            end
        end
    end

    assign O_TX    = shift_q[0];
    assign O_TXRDY = txrdy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine
// Drives directed and random frames into uart_tx_engine and compares the line
// and ready outputs every clock against a reference frame model.
module tb_uart_tx_engine;

    localparam int BAUD_W = 20;

    logic              I_CLK = 1'b0;
    logic              I_RESET;
    logic [7:0]        I_DATA;
    logic              I_LOAD;
    logic [BAUD_W-1:0] I_BAUD_K;
    logic              I_EIGHT;
    logic              I_PEN;
    logic              I_OHEL;
    logic              O_TX;
    logic              O_TXRDY;

    int checks   = 0;
    int failures = 0;

    always #5 I_CLK = ~I_CLK;

    uart_tx_engine #(
        .BAUD_W(BAUD_W)
    ) dut (
        .I_CLK   (I_CLK),
        .I_RESET (I_RESET),
        .I_DATA  (I_DATA),
        .I_LOAD  (I_LOAD),
        .I_BAUD_K(I_BAUD_K),
        .I_EIGHT (I_EIGHT),
        .I_PEN   (I_PEN),
        .I_OHEL  (I_OHEL),
        .O_TX    (O_TX),
        .O_TXRDY (O_TXRDY)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity chosen so the
    // total count of ones is even/odd, remaining slots are ones.
    function automatic void model_frame(input logic [7:0] d, input logic eight,
                                        input logic pen, input logic ohel,
                                        output logic [10:0] bits);
        int nd;
        int ones;
        nd   = eight ? 8 : 7;
        ones = 0;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < nd; i++) begin
            bits[1+i] = d[i];
            ones += int'(d[i]);
        end
        if (pen) begin
            bits[1+nd] = ohel ? ((ones % 2) == 0) : ((ones % 2) == 1);
        end
    endfunction

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check_val({tag, "_idle_tx"}, O_TX, 1);
            check_val({tag, "_idle_rdy"}, O_TXRDY, 1);
            @(negedge I_CLK);
        end
    endtask

    // Called at a negedge with the engine idle. Returns at the negedge where
    // ready should be back, so a following call loads back-to-back.
    // busy_at: clock index within the frame at which a 0xFF load is pulsed.
    // abort_at: clock index at which reset is applied and the frame dropped.
    task automatic send_frame(input logic [7:0] d, input logic [BAUD_W-1:0] k,
                              input logic e, input logic p, input logic o,
                              input int busy_at, input int abort_at, input string tag);
        logic [10:0] bits;
        int          keff;
        model_frame(d, e, p, o, bits);
        keff     = (k == '0) ? 1 : int'(k);
        I_DATA   = d;
        I_BAUD_K = k;
        I_EIGHT  = e;
        I_PEN    = p;
        I_OHEL   = o;
        I_LOAD   = 1'b1;
        @(negedge I_CLK);
        I_LOAD   = 1'b0;
        I_DATA   = 8'($urandom);
        I_BAUD_K = BAUD_W'($urandom_range(1, 7));
        I_EIGHT  = 1'($urandom);
        I_PEN    = 1'($urandom);
        I_OHEL   = 1'($urandom);
        for (int t = 0; t < 11 * keff; t++) begin
            if (t == abort_at) begin
                I_RESET = 1'b1;
                @(negedge I_CLK);
                I_RESET = 1'b0;
                check_val({tag, "_rst_tx"}, O_TX, 1);
                check_val({tag, "_rst_rdy"}, O_TXRDY, 1);
                return;
            end
            check_val({tag, "_tx"}, O_TX, bits[t/keff]);
            check_val({tag, "_rdy"}, O_TXRDY, 0);
            if (t == busy_at) begin
                I_LOAD = 1'b1;
                I_DATA = 8'hFF;
            end else begin
                I_LOAD = 1'b0;
            end
            @(negedge I_CLK);
        end
        I_LOAD = 1'b0;
        check_val({tag, "_end_tx"}, O_TX, 1);
        check_val({tag, "_end_rdy"}, O_TXRDY, 1);
    endtask

    initial begin
        I_RESET  = 1'b1;
        I_LOAD   = 1'b0;
        I_DATA   = 8'h00;
        I_BAUD_K = BAUD_W'(4);
        I_EIGHT  = 1'b1;
        I_PEN    = 1'b0;
        I_OHEL   = 1'b0;
        repeat (3) @(negedge I_CLK);
        check_val("reset_tx", O_TX, 1);
        check_val("reset_rdy", O_TXRDY, 1);
        I_RESET = 1'b0;
        idle_check(100, "post_reset");

        send_frame(8'h55, BAUD_W'(4), 1'b1, 1'b0, 1'b0, -1, -1, "f8n_55");
        idle_check(3, "g1");
        send_frame(8'h41, BAUD_W'(4), 1'b0, 1'b1, 1'b0, -1, -1, "f7pe_41");
        idle_check(2, "g2");
        send_frame(8'h41, BAUD_W'(4), 1'b0, 1'b1, 1'b1, -1, -1, "f7po_41");
        idle_check(2, "g3");
        send_frame(8'hC3, BAUD_W'(3), 1'b1, 1'b1, 1'b1, -1, -1, "f8po_c3");
        idle_check(2, "g4");
        send_frame(8'h00, BAUD_W'(4), 1'b1, 1'b0, 1'b0, 10, -1, "busy_00");
        idle_check(20, "busy_after");

        send_frame(8'hA5, BAUD_W'(4), 1'b1, 1'b0, 1'b0, -1, -1, "b2b_a5");
        send_frame(8'h3C, BAUD_W'(4), 1'b1, 1'b0, 1'b0, -1, -1, "b2b_3c");
        idle_check(2, "g5");

        send_frame(8'h9E, BAUD_W'(4), 1'b1, 1'b1, 1'b0, -1, 20, "abort");
        idle_check(5, "abort_after");
        send_frame(8'h12, BAUD_W'(1), 1'b1, 1'b0, 1'b0, -1, -1, "k1_12");
        idle_check(2, "g6");
        send_frame(8'h6B, BAUD_W'(0), 1'b0, 1'b1, 1'b0, -1, -1, "k0_6b");
        idle_check(2, "g7");

        for (int n = 0; n < 40; n++) begin
            send_frame(8'($urandom), BAUD_W'($urandom_range(1, 6)), 1'($urandom),
                       1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1,
                       -1, "rand");
            idle_check(int'($urandom_range(0, 3)), "rand_gap");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
